// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encodings, frame constants and default cycle counts
package ps2_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } ps2_tx_state_t;
  localparam int PS2_DATA_BITS = 8;
  localparam logic [3:0] PAR_IDX = 4'd8;
  localparam logic [3:0] ACK_IDX = 4'd9;
  localparam int DEF_INHIBIT_CYCLES = 10000;
  localparam int DEF_TIMEOUT_CYCLES = 1500000;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer with falling-edge detect for one PS/2 line
module ps2_line_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic line,
  output logic sync,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge sys_clk) begin
    if (!rst_n) {meta, sync, prev} <= 3'b111;
    else {meta, sync, prev} <= {line, meta, sync};
  end
  assign fall = prev & ~sync;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter using request-to-send
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low
);
  localparam int CW = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);
  ps2_tx_state_t state;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic par;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
  logic clk_s, clk_fall, data_s, data_fall_unused;
  logic watching, timeout;
  ps2_line_sync u_clk_sync (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .line   (ps2_clk_in),
    .sync   (clk_s),
    .fall   (clk_fall)
  );
  ps2_line_sync u_data_sync (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .line   (ps2_data_in),
    .sync   (data_s),
    .fall   (data_fall_unused)
  );
  assign busy = ~tx_ready;
  assign watching = (state == S_REQ) || (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout = watching && !clk_fall && (cnt == '0);
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tx_ready     <= 1'b1;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      shreg        <= '0;
      par          <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
    end else begin
      tx_done <= 1'b0;
      if (watching) cnt <= clk_fall ? TO_LOAD : cnt - 1'b1;
      case (state)
        S_IDLE: if (tx_valid) begin
          shreg       <= tx_data;
          par         <= ~^tx_data;
          tx_error    <= 1'b0;
          cnt         <= INH_LOAD;
          ps2_clk_low <= 1'b1;
          tx_ready    <= 1'b0;
          state       <= S_INHIBIT;
        end
        S_INHIBIT: if (cnt == '0) begin
          ps2_clk_low  <= 1'b0;
          ps2_data_low <= 1'b1;
          cnt          <= TO_LOAD;
          state        <= S_REQ;
        end else cnt <= cnt - 1'b1;
        S_REQ: if (clk_fall) begin
          ps2_data_low <= ~shreg[0];
          idx          <= 4'd1;
          state        <= S_SHIFT;
        end
        S_SHIFT: if (clk_fall) begin
          ps2_data_low <= (idx == ACK_IDX) ? 1'b0 : (idx == PAR_IDX) ? ~par : ~shreg[idx[2:0]];
          idx          <= idx + 1'b1;
          if (idx == ACK_IDX) state <= S_ACK;
        end
        S_ACK: if (clk_fall) begin
          tx_error <= data_s;
          state    <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: if (clk_s && data_s) begin
          tx_done  <= 1'b1;
          tx_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (timeout) begin
        ps2_clk_low  <= 1'b0;
        ps2_data_low <= 1'b0;
        tx_error     <= 1'b1;
        tx_done      <= 1'b1;
        tx_ready     <= 1'b1;
        state        <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench with a behavioural PS/2 keyboard model
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int TO = 100;
  localparam int HALF = 20;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, tx_done, tx_error, busy, ps2_clk_low, ps2_data_low;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  bit dev_abort = 1'b0;
  wire clk_line = ~(ps2_clk_low | dev_clk_low);
  wire data_line = ~(ps2_data_low | dev_data_low);
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int clk_rises = 0;
  int run = 0;
  int inhibit_len = 0;
  int dev_falls = 0;
  logic inh_data = 1'b0;
  logic prev_cl = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .busy        (busy),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_low (ps2_clk_low),
    .ps2_data_low(ps2_data_low)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (ps2_clk_low === 1'b1) begin
      run <= (prev_cl === 1'b1) ? run + 1 : 1;
      if (prev_cl !== 1'b1) clk_rises <= clk_rises + 1;
    end else if (prev_cl === 1'b1) begin
      inhibit_len <= run;
      inh_data    <= ps2_data_low;
    end
    prev_cl <= ps2_clk_low;
  end

  // Expected frame on the wire: data LSB first, odd parity, stop bit 1
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic dev_run(input bit ack, output logic [10:0] bits, output bit ok);
    int n;
    ok = 1'b0;
    bits = '0;
    n = 0;
    while (!(clk_line === 1'b1 && data_line === 1'b0) && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 1000) return;
    repeat (HALF) @(negedge sys_clk);
    for (int k = 0; k < 11; k++) begin
      if (dev_abort) break;
      dev_clk_low = 1'b1;
      dev_falls++;
      repeat (HALF) @(negedge sys_clk);
      dev_clk_low = 1'b0;
      bits[k] = data_line;
      if (k == 9 && ack) dev_data_low = 1'b1;
      if (k < 10) repeat (HALF) @(negedge sys_clk);
    end
    dev_data_low = 1'b0;
    dev_clk_low = 1'b0;
    ok = !dev_abort;
  endtask

  task automatic send(input logic [7:0] d, input bit ack, output logic [10:0] bits, output bit ok,
                      output bit got_done);
    int n;
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    compared++;
    if (ps2_clk_low !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_clk_low: clk_low=%b busy=%b, want 1 1", ps2_clk_low, busy);
    end
    dev_run(ack, bits, ok);
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    got_done = (tx_done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    compared++;
    if ({tx_ready, busy, tx_done, tx_error, ps2_clk_low, ps2_data_low} !== 6'b100000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 100000",
               {tx_ready, busy, tx_done, tx_error, ps2_clk_low, ps2_data_low});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    compared++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: ready=%b busy=%b want 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_send_ed();
    logic [10:0] bits;
    bit ok, gd;
    int d0;
    d0 = done_cnt;
    send(8'hED, 1'b1, bits, ok, gd);
    compared++;
    if (bits[9:0] !== frame_of(8'hED) || !ok) begin
      mismatched++;
      $display("FAIL ed_frame: got %b ok=%0d want %b", bits[9:0], ok, frame_of(8'hED));
    end
    compared++;
    if (inhibit_len != INH || inh_data !== 1'b1) begin
      mismatched++;
      $display("FAIL ed_inhibit: len=%0d data_low=%b want %0d 1", inhibit_len, inh_data, INH);
    end
    compared++;
    if (!gd || tx_error !== 1'b0 || tx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ed_done: done=%0d err=%b ready=%b want 1 0 1", gd, tx_error, tx_ready);
    end
    @(negedge sys_clk);
    compared++;
    if (tx_done !== 1'b0 || done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL ed_done_pulse: done=%b pulses=%0d want 0 1", tx_done, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2;
    bit ok1, ok2, gd1, gd2;
    send(8'h01, 1'b1, b1, ok1, gd1);
    compared++;
    if (!gd1 || tx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ready_with_done: done=%0d ready=%b want 1 1", gd1, tx_ready);
    end
    send(8'h00, 1'b1, b2, ok2, gd2);
    compared++;
    if (b1[9:0] !== frame_of(8'h01) || !ok1) begin
      mismatched++;
      $display("FAIL b2b_frame01: got %b want %b", b1[9:0], frame_of(8'h01));
    end
    compared++;
    if (b2[9:0] !== frame_of(8'h00) || !ok2 || !gd2 || tx_error !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_frame00: got %b done=%0d err=%b want %b 1 0", b2[9:0], gd2, tx_error,
               frame_of(8'h00));
    end
  endtask

  task automatic test_random();
    logic [10:0] bits;
    logic [7:0] d;
    bit ok, gd;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send(d, 1'b1, bits, ok, gd);
      compared++;
      if (bits[9:0] !== frame_of(d) || !ok || !gd || tx_error !== 1'b0) begin
        mismatched++;
        $display("FAIL rand_frame[%0d]: data=%h got %b done=%0d err=%b want %b 1 0", i, d,
                 bits[9:0], gd, tx_error, frame_of(d));
      end
      repeat ($urandom_range(0, 5)) @(negedge sys_clk);
    end
  endtask

  task automatic test_no_clock();
    int n;
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_data_low !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    n = 0;
    while (ps2_data_low === 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    compared++;
    if (n != TO) begin
      mismatched++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TO);
    end
    compared++;
    if (tx_done !== 1'b1 || tx_error !== 1'b1 || ps2_clk_low !== 1'b0 || tx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_flags: done=%b err=%b clk_low=%b ready=%b want 1 1 0 1", tx_done,
               tx_error, ps2_clk_low, tx_ready);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    logic [7:0] d;
    bit ok, gd;
    d = 8'($urandom);
    send(d, 1'b0, bits, ok, gd);
    compared++;
    if (!gd || tx_error !== 1'b1 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
      mismatched++;
      $display("FAIL no_ack: done=%0d err=%b clk_low=%b data_low=%b want 1 1 0 0", gd, tx_error,
               ps2_clk_low, ps2_data_low);
    end
    compared++;
    if (bits[9:0] !== frame_of(d)) begin
      mismatched++;
      $display("FAIL no_ack_frame: got %b want %b", bits[9:0], frame_of(d));
    end
    @(negedge sys_clk);
  endtask

  task automatic test_ignored();
    logic [10:0] bits;
    bit ok, gd;
    int r0;
    r0 = clk_rises;
    fork
      send(8'hED, 1'b1, bits, ok, gd);
      begin
        repeat (2) @(negedge sys_clk);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        repeat (200) @(negedge sys_clk);
        tx_valid = 1'b0;
      end
    join
    repeat (50) @(negedge sys_clk);
    compared++;
    if (bits[9:0] !== frame_of(8'hED) || !gd || tx_error !== 1'b0) begin
      mismatched++;
      $display("FAIL ignored_frame: got %b done=%0d err=%b want %b 1 0", bits[9:0], gd, tx_error,
               frame_of(8'hED));
    end
    compared++;
    if (clk_rises - r0 != 1) begin
      mismatched++;
      $display("FAIL ignored_requests: transfers=%0d want 1", clk_rises - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    bit ok, gd;
    int d0, n;
    d0 = done_cnt;
    fork
      send(8'hA5, 1'b1, bits, ok, gd);
      begin
        n = 0;
        while (dev_falls % 11 != 5 && n < 2000) begin
          @(negedge sys_clk);
          n++;
        end
        repeat (8) @(negedge sys_clk);
        rst_n = 1'b0;
        dev_abort = 1'b1;
        d0 = done_cnt;
        @(negedge sys_clk);
        compared++;
        if (ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
          mismatched++;
          $display("FAIL mid_reset_release: clk_low=%b data_low=%b ready=%b done=%b want 0 0 1 0",
                   ps2_clk_low, ps2_data_low, tx_ready, tx_done);
        end
        rst_n = 1'b1;
      end
    join
    compared++;
    if (done_cnt != d0 || gd) begin
      mismatched++;
      $display("FAIL mid_reset_no_done: pulses=%0d want 0", done_cnt - d0);
    end
    dev_abort = 1'b0;
    repeat (20) @(negedge sys_clk);
    send(8'hFF, 1'b1, bits, ok, gd);
    compared++;
    if (bits[9:0] !== frame_of(8'hFF) || !ok || !gd || tx_error !== 1'b0) begin
      mismatched++;
      $display("FAIL after_reset_ff: got %b done=%0d err=%b want %b 1 0", bits[9:0], gd, tx_error,
               frame_of(8'hFF));
    end
  endtask

  initial begin
    dev_falls = 0;
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_random();
    test_no_clock();
    test_no_ack();
    test_ignored();
    dev_falls = 0;
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
